// File: rtl/ft600_fifo_bridge.sv
// ft600_fifo_bridge
//   FT600/FT601 245-mode synchronous FIFO master. Everything runs on i_ft_clk.
//   The bridge arbitrates between chip->fabric reads and fabric->chip writes.
//   Each direction is buffered in a first-word-fall-through FIFO, and fabric
//   logic sees valid/ready streams.
//   Optional build macro: FT_LOOPBACK_EN. When it is defined, the RX FIFO output
//   is fed straight into the TX FIFO, so every received word is echoed back to
//   the host. The fabric streams are then disabled.
// Ports
//   i_ft_clk, i_rst          : clock, synchronous active-high reset
//   io_ft_data, io_ft_be     : FT bus, driven by this block only while writing
//   i_ft_txe_n, i_ft_rxf_n   : chip TX-space / RX-data flags (active low)
//   o_ft_wr_n/rd_n/oe_n      : registered bus strobes (active low)
//   o_rx_*, i_rx_ready       : host->fabric stream
//   i_tx_*, o_tx_ready       : fabric->host stream
//   o_rx_level, o_tx_level   : FIFO occupancy
//
// state | meaning
// IDLE  | arbitrate between pending read and pending write
// RD_OE | chip output enable asserted, bus turning toward the FPGA
// RD    | read strobe low, one word captured per edge with rxf_n low
// WR    | FPGA drives the bus, one word retired per edge with txe_n low
// TA    | turnaround: strobes high, bus released
module ft600_fifo_bridge #(
   parameter int DATA_WIDTH = 16,
   parameter int BE_WIDTH   = DATA_WIDTH/8,
   parameter int DEPTH      = 512,
   parameter int MAX_BURST  = 256
) (
   input  logic                      i_ft_clk,
   input  logic                      i_rst,
   inout  wire  [DATA_WIDTH-1:0]     io_ft_data,
   inout  wire  [BE_WIDTH-1:0]       io_ft_be,
   input  logic                      i_ft_txe_n,
   input  logic                      i_ft_rxf_n,
   output logic                      o_ft_wr_n,
   output logic                      o_ft_rd_n,
   output logic                      o_ft_oe_n,
   output logic [DATA_WIDTH-1:0]     o_rx_data,
   output logic [BE_WIDTH-1:0]       o_rx_be,
   output logic                      o_rx_valid,
   input  logic                      i_rx_ready,
   input  logic [DATA_WIDTH-1:0]     i_tx_data,
   input  logic [BE_WIDTH-1:0]       i_tx_be,
   input  logic                      i_tx_valid,
   output logic                      o_tx_ready,
   output logic [$clog2(DEPTH):0]    o_rx_level,
   output logic [$clog2(DEPTH):0]    o_tx_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int WW = DATA_WIDTH + BE_WIDTH;
   localparam int BW = $clog2(MAX_BURST + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD_OE = 3'd1;
   localparam logic [2:0] S_RD    = 3'd2;
   localparam logic [2:0] S_WR    = 3'd3;
   localparam logic [2:0] S_TA    = 3'd4;

   logic [WW-1:0] rx_mem_q [DEPTH];
   logic [WW-1:0] tx_mem_q [DEPTH];
   logic [AW-1:0] rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
   logic [LW-1:0] rx_level_q, tx_level_q;
   logic [2:0]    state_q;
   logic [BW-1:0] burst_q;
   logic [WW-1:0] dout_q;
   logic          rd_n_q, oe_n_q, wr_n_q, drive_q, last_wr_q;

   logic          rx_push, rx_pop, tx_push, tx_pop;
   logic          rx_nempty, tx_rdy, rx_free_gt2, rd_pend, wr_pend, burst_last;
   logic [WW-1:0] rx_head, tx_din, tx_head, tx_next;
   logic [BW-1:0] burst_inc;

   assign rx_head     = rx_mem_q[rx_rp_q];
   assign tx_head     = tx_mem_q[tx_rp_q];
   assign tx_next     = tx_mem_q[tx_rp_q + AW'(1)];
   assign rx_nempty   = (rx_level_q != '0);
   assign tx_rdy      = (tx_level_q != LW'(DEPTH)) && !i_rst;
   assign rx_free_gt2 = (rx_level_q < LW'(DEPTH - 2));
   assign rd_pend     = !i_ft_rxf_n && rx_free_gt2;
   assign wr_pend     = !i_ft_txe_n && (tx_level_q != '0);
   assign burst_inc   = burst_q + BW'(1);
   assign burst_last  = (burst_inc == BW'(MAX_BURST));

   // Full guard is belt-and-braces; the free>2 margin already prevents it.
   assign rx_push = (state_q == S_RD) && !rd_n_q && !i_ft_rxf_n &&
                    (rx_level_q != LW'(DEPTH));
   assign tx_pop  = (state_q == S_WR) && !wr_n_q && !i_ft_txe_n;

`ifdef FT_LOOPBACK_EN
   assign rx_pop     = rx_nempty && tx_rdy;
   assign tx_push    = rx_pop;
   assign tx_din     = rx_head;
   assign o_rx_valid = 1'b0;
   assign o_tx_ready = 1'b0;
   wire unused_fabric = ^{i_rx_ready, i_tx_data, i_tx_be, i_tx_valid};
`else
   assign rx_pop     = rx_nempty && i_rx_ready;
   assign tx_push    = i_tx_valid && tx_rdy;
   assign tx_din     = {i_tx_be, i_tx_data};
   assign o_rx_valid = rx_nempty;
   assign o_tx_ready = tx_rdy;
`endif

   assign o_rx_data  = rx_head[DATA_WIDTH-1:0];
   assign o_rx_be    = rx_head[WW-1:DATA_WIDTH];
   assign o_rx_level = rx_level_q;
   assign o_tx_level = tx_level_q;
   assign o_ft_rd_n  = rd_n_q;
   assign o_ft_oe_n  = oe_n_q;
   assign o_ft_wr_n  = wr_n_q;
   assign io_ft_data = drive_q ? dout_q[DATA_WIDTH-1:0] : {DATA_WIDTH{1'bz}};
   assign io_ft_be   = drive_q ? dout_q[WW-1:DATA_WIDTH] : {BE_WIDTH{1'bz}};

   always_ff @(posedge i_ft_clk) begin
      if (rx_push) rx_mem_q[rx_wp_q] <= {io_ft_be, io_ft_data};
      if (tx_push) tx_mem_q[tx_wp_q] <= tx_din;
   end

   always_ff @(posedge i_ft_clk) begin
      if (i_rst) begin
         rx_wp_q    <= '0;
         rx_rp_q    <= '0;
         tx_wp_q    <= '0;
         tx_rp_q    <= '0;
         rx_level_q <= '0;
         tx_level_q <= '0;
      end else begin
         if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
         if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
         if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
         if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_level_q <= rx_level_q + LW'(1);
            2'b01:   rx_level_q <= rx_level_q - LW'(1);
            default: rx_level_q <= rx_level_q;
         endcase
         case ({tx_push, tx_pop})
            2'b10:   tx_level_q <= tx_level_q + LW'(1);
            2'b01:   tx_level_q <= tx_level_q - LW'(1);
            default: tx_level_q <= tx_level_q;
         endcase
      end
   end

   always_ff @(posedge i_ft_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         rd_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         drive_q   <= 1'b0;
         burst_q   <= '0;
         last_wr_q <= 1'b1;
         dout_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // On a tie, serve the direction not served last time.
               if (rd_pend && (!wr_pend || last_wr_q)) begin
                  state_q   <= S_RD_OE;
                  oe_n_q    <= 1'b0;
                  last_wr_q <= 1'b0;
               end else if (wr_pend) begin
                  state_q   <= S_WR;
                  wr_n_q    <= 1'b0;
                  drive_q   <= 1'b1;
                  dout_q    <= tx_head;
                  burst_q   <= '0;
                  last_wr_q <= 1'b1;
               end
            end
            S_RD_OE: begin
               state_q <= S_RD;
               rd_n_q  <= 1'b0;
               burst_q <= '0;
            end
            S_RD: begin
               if (rx_push) burst_q <= burst_inc;
               if (i_ft_rxf_n || !rx_free_gt2 || (rx_push && burst_last)) begin
                  state_q <= S_TA;
                  rd_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
               end
            end
            S_WR: begin
               if (tx_pop) begin
                  burst_q <= burst_inc;
                  dout_q  <= tx_next;
                  // Level 1 before the pop means the head just left; tx_next
                  // would be stale, so leave even if a push lands this edge.
                  if ((tx_level_q == LW'(1)) || burst_last) begin
                     state_q <= S_TA;
                     wr_n_q  <= 1'b1;
                     drive_q <= 1'b0;
                  end
               end else if (i_ft_txe_n) begin
                  state_q <= S_TA;
                  wr_n_q  <= 1'b1;
                  drive_q <= 1'b0;
               end
            end
            S_TA:    state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ft600_fifo_bridge.sv
module tb_ft600_fifo_bridge;

   localparam int DW    = 16;
   localparam int BEW   = 2;
   localparam int DEPTH = 16;
   localparam int MAXB  = 8;

   logic          clk = 1'b0;
   logic          rst;
   wire  [DW-1:0] ft_data;
   wire  [BEW-1:0] ft_be;
   logic          ft_txe_n = 1'b1;
   logic          ft_rxf_n = 1'b1;
   logic          wr_n, rd_n, oe_n;
   logic [DW-1:0] rx_data;
   logic [BEW-1:0] rx_be;
   logic          rx_valid, rx_ready;
   logic [DW-1:0] tx_data;
   logic [BEW-1:0] tx_be;
   logic          tx_valid, tx_ready;
   logic [4:0]    rx_level, tx_level;

   logic [17:0]   chip_q[$];
   logic [17:0]   rx_sb[$];
   logic [17:0]   host_sb[$];
   logic [17:0]   chip_head = '0;
   logic          rxf_hold = 1'b1;
   logic          txe_hold = 1'b1;
   int            checks = 0;
   int            errors = 0;
   int            wr_count = 0;

   logic          grant_en = 1'b0;
   int            gdir[$];
   int            gwords[$];
   int            gta[$];

   always #5 clk = ~clk;

   assign ft_data = !oe_n ? chip_head[15:0]  : 16'bz;
   assign ft_be   = !oe_n ? chip_head[17:16] : 2'bz;

   ft600_fifo_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
      .i_ft_clk(clk), .i_rst(rst),
      .io_ft_data(ft_data), .io_ft_be(ft_be),
      .i_ft_txe_n(ft_txe_n), .i_ft_rxf_n(ft_rxf_n),
      .o_ft_wr_n(wr_n), .o_ft_rd_n(rd_n), .o_ft_oe_n(oe_n),
      .o_rx_data(rx_data), .o_rx_be(rx_be), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
      .i_tx_data(tx_data), .i_tx_be(tx_be), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
      .o_rx_level(rx_level), .o_tx_level(tx_level)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic strobe(input int sel);
      case (sel)
         0:       return oe_n;
         1:       return rd_n;
         default: return wr_n;
      endcase
   endfunction

   task automatic wait_low(input string tag, input int sel);
      int n = 0;
      while (strobe(sel) != 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, strobe(sel), 0);
   endtask

   task automatic push_tx(input logic [17:0] w);
      {tx_be, tx_data} = w;
      tx_valid = 1'b1;
      @(posedge clk);
      check("tx_ready", tx_ready, 1);
      host_sb.push_back(w);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // FT600 chip model: serves reads from chip_q, checks writes against host_sb.
   initial begin
      logic rd_take, wr_take, prev_oe, prev_wr, idle_seen;
      logic [17:0] wword;
      int idx;
      prev_oe = 1'b1;
      prev_wr = 1'b1;
      idle_seen = 1'b0;
      forever begin
         @(posedge clk);
         rd_take = !rd_n && !ft_rxf_n;
         wr_take = !wr_n && !ft_txe_n;
         wword   = {ft_be, ft_data};
         if (grant_en) begin
            if (prev_oe && !oe_n) begin
               gdir.push_back(0); gwords.push_back(0); gta.push_back(int'(idle_seen)); idle_seen = 1'b0;
            end
            if (prev_wr && !wr_n) begin
               gdir.push_back(1); gwords.push_back(0); gta.push_back(int'(idle_seen)); idle_seen = 1'b0;
            end
            if (oe_n && rd_n && wr_n) idle_seen = 1'b1;
            if ((rd_take || wr_take) && gwords.size() > 0) begin
               idx = gwords.size() - 1;
               gwords[idx] = gwords[idx] + 1;
            end
         end
         prev_oe = oe_n;
         prev_wr = wr_n;
         #1;
         if (rd_take && chip_q.size() > 0) void'(chip_q.pop_front());
         if (wr_take && !rst) begin
            wr_count++;
            check("host_sb_nonempty", 32'(host_sb.size() > 0), 1);
            if (host_sb.size() > 0) check("host_word", wword, host_sb.pop_front());
         end
         chip_head = (chip_q.size() > 0) ? chip_q[0] : 18'h0;
         ft_rxf_n  = rxf_hold || (chip_q.size() == 0);
         ft_txe_n  = txe_hold;
      end
   end

   // Fabric RX monitor.
   initial begin
      forever begin
         @(posedge clk);
         if (!rst) begin
            if (rx_level > 5'(DEPTH)) check("rx_level_bound", rx_level, DEPTH);
            if (rx_valid && rx_ready) begin
               check("rx_sb_nonempty", 32'(rx_sb.size() > 0), 1);
               if (rx_sb.size() > 0) check("rx_word", {rx_be, rx_data}, rx_sb.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [17:0] w;
      rst = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_be = '0;
      repeat (3) @(negedge clk);
      check("rst_wr_n", wr_n, 1);
      check("rst_rd_n", rd_n, 1);
      check("rst_oe_n", oe_n, 1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_level", rx_level, 0);
      check("rst_tx_level", tx_level, 0);
      check("rst_tx_ready", tx_ready, 0);
      rst = 1'b0;
      @(negedge clk);
`ifndef FT_LOOPBACK_EN
      check("tx_ready_after_rst", tx_ready, 1);

      // 8-word read burst, fabric not ready
      for (int i = 0; i < 8; i++) begin
         w = {2'b11, 16'h1000 + 16'(i)};
         chip_q.push_back(w); rx_sb.push_back(w);
      end
      rxf_hold = 1'b0;
      wait_low("oe_low", 0);
      check("rd_after_oe", rd_n, 1);
      @(negedge clk);
      check("rd_low", rd_n, 0);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check("rd_hold", rd_n, 0);
      end
      @(negedge clk);
      check("rd_end", rd_n, 1);
      check("oe_end", oe_n, 1);
      check("rx_level8", rx_level, 8);
      check("rx_valid8", rx_valid, 1);
      rx_ready = 1'b1;
      repeat (12) @(negedge clk);
      check("rx_drain", rx_level, 0);
      check("rx_sb_empty1", rx_sb.size(), 0);

      // back-pressure: fabric stalled, 20 words offered
      rx_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         w = {2'(i), 16'h2000 + 16'(i)};
         chip_q.push_back(w); rx_sb.push_back(w);
      end
      repeat (40) @(negedge clk);
      check("bp_level", rx_level, 15);
      check("bp_rd_n", rd_n, 1);
      check("bp_oe_n", oe_n, 1);
      check("bp_chip_left", chip_q.size(), 5);
      rx_ready = 1'b1;
      repeat (40) @(negedge clk);
      check("bp_drain", rx_level, 0);
      check("bp_sb_empty", rx_sb.size(), 0);
      check("bp_chip_empty", chip_q.size(), 0);

      // 4-word write
      for (int i = 0; i < 4; i++) push_tx({2'b11, 16'h00A0 + 16'(i)});
      check("tx_level4", tx_level, 4);
      txe_hold = 1'b0;
      wait_low("wr_low", 2);
      for (int k = 0; k < 4; k++) begin
         check("wr_burst", wr_n, 0);
         @(negedge clk);
      end
      check("wr_end", wr_n, 1);
      check("tx_empty", tx_level, 0);
      check("host_sb_empty1", host_sb.size(), 0);

      // not-ready during the 2nd word
      txe_hold = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) push_tx({2'b01, 16'h00B0 + 16'(i)});
      txe_hold = 1'b0;
      wait_low("wr2_low", 2);
      txe_hold = 1'b1;
      @(negedge clk);
      check("stall_wr_b1", wr_n, 0);
      @(negedge clk);
      check("stall_ta", wr_n, 1);
      check("stall_level", tx_level, 3);
      repeat (2) @(negedge clk);
      txe_hold = 1'b0;
      repeat (12) @(negedge clk);
      check("stall_tx_empty", tx_level, 0);
      check("stall_sb_empty", host_sb.size(), 0);

      // both directions pending: last served was write, so read goes first
      rxf_hold = 1'b1; txe_hold = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         w = {2'b10, 16'h3000 + 16'(i)};
         chip_q.push_back(w); rx_sb.push_back(w);
      end
      for (int i = 0; i < 12; i++) push_tx({2'b11, 16'h00C0 + 16'(i)});
      grant_en = 1'b1;
      rxf_hold = 1'b0; txe_hold = 1'b0;
      repeat (80) @(negedge clk);
      grant_en = 1'b0;
      check("grant_count", 32'(gdir.size() >= 3), 1);
      if (gdir.size() >= 3) begin
         for (int k = 0; k < 3; k++) begin
            check("grant_dir", gdir[k], (k == 1) ? 1 : 0);
            check("grant_words", gwords[k], MAXB);
            if (k > 0) check("grant_ta", gta[k], 1);
         end
      end
      check("arb_tx_empty", tx_level, 0);
      check("arb_host_sb", host_sb.size(), 0);
      check("arb_rx_sb", rx_sb.size(), 0);

      // reset mid-read
      rx_ready = 1'b0; rxf_hold = 1'b1; txe_hold = 1'b1;
      repeat (3) @(negedge clk);
      push_tx(18'h0DEAD);
      push_tx(18'h0BEEF);
      for (int i = 0; i < 10; i++) chip_q.push_back({2'b11, 16'h4000 + 16'(i)});
      rxf_hold = 1'b0;
      wait_low("rst_rd_low", 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_rd_n", rd_n, 1);
      check("mid_rst_oe_n", oe_n, 1);
      check("mid_rst_wr_n", wr_n, 1);
      check("mid_rst_rx_level", rx_level, 0);
      check("mid_rst_tx_level", tx_level, 0);
      check("mid_rst_rx_valid", rx_valid, 0);
      check("mid_rst_tx_ready", tx_ready, 0);
      rxf_hold = 1'b1;
      chip_q.delete(); rx_sb.delete(); host_sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_rd_n", rd_n, 1);
      check("post_rst_rx_level", rx_level, 0);
`else
      chip_q.push_back({2'b11, 16'h55AA});
      host_sb.push_back({2'b11, 16'h55AA});
      rxf_hold = 1'b0;
      txe_hold = 1'b0;
      repeat (30) @(negedge clk);
      check("lb_writes", wr_count, 1);
      check("lb_host_sb", host_sb.size(), 0);
      check("lb_rx_valid", rx_valid, 0);
      check("lb_tx_ready", tx_ready, 0);
      check("lb_levels", {rx_level, tx_level}, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
